mips_fetch: RTL and testbench

Instruction fetch stage of the MIPS datapath. Owns the program counter and issues word reads to instruction memory over a request/grant/response handshake. Buffers returned words in a small in-order queue and presents them, with their PC and pre-split `opcode`/`fcode` fields, to the control decoder and register-read stage under a valid/ready handshake. Accepts a redirect (taken branch, `j`, `jal`) that flushes buffered and in-flight instructions and restarts fetch at the new PC.

---
 rtl/mips_pkg.sv | 41 ++++
 rtl/mips_fetch_if.sv | 33 +++
 rtl/mips_fetch_fifo.sv | 51 +++++
 rtl/mips_fetch.sv | 117 +++++++++++
 tb/tb_mips_fetch.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct constants, reset PC and instruction field slices.
// Used by the fetch stage and the control decoder.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  function automatic logic [5:0] op_of(input logic [31:0] i);
    return i[OP_HI:OP_LO];
  endfunction

  function automatic logic [5:0] fn_of(input logic [31:0] i);
    return i[FN_HI:FN_LO];
  endfunction

endpackage

// File: rtl/mips_fetch_if.sv
// Fetch stage bus bundle: imem request/grant/response, redirect, and the
// valid/ready instruction stream towards decode.
interface mips_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [5:0]  opcode;
  logic [5:0]  fcode;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output instr_valid, instr, instr_pc, opcode, fcode,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  instr_valid, instr, instr_pc, opcode, fcode,
    output instr_ready
  );
endinterface

// File: rtl/mips_fetch_fifo.sv
// Synchronous FIFO with flush; head is read straight from registered storage,
// so a push becomes visible the cycle after it is written.
module mips_fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/mips_fetch.sv
// MIPS instruction fetch: PC, credit-limited imem reads, in-order buffer, redirect flush.
// Optional MIPS_FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module mips_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  mips_fetch_if.master bus
`ifdef MIPS_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] outst, occ;
  logic [31:0]   tag;
  logic          gnt, rsp, drop_rsp, buf_push, buf_pop, buf_vld;
  fetch_entry_t  push_e, head;
  logic          unused_rpc;

  assign unused_rpc = ^bus.redirect_pc[1:0];

  assign gnt      = bus.imem_req && bus.imem_gnt;
  assign rsp      = bus.imem_rvalid;
  assign drop_rsp = rsp && ((drop_q != '0) || bus.redirect);
  assign buf_push = rsp && !drop_rsp;
  assign buf_vld  = occ != '0;
  assign buf_pop  = buf_vld && bus.instr_ready && !bus.redirect;

  // Credit: every outstanding read has a reserved buffer slot, so rvalid never stalls.
  assign bus.imem_req  = !rst && ((SW'(outst) + SW'(occ)) < SW'(DEPTH));
  assign bus.imem_addr = pc_q;

  // Tag queue depth tracks granted-but-unreturned reads, dropped ones included.
  mips_fetch_fifo #(.W(32), .DEPTH(DEPTH)) u_tagq (
    .clk     (clk),
    .rst     (rst),
    .flush_i (1'b0),
    .push_i  (gnt),
    .data_i  (pc_q),
    .pop_i   (rsp),
    .data_o  (tag),
    .count_o (outst)
  );

  assign push_e = '{pc: tag, word: bus.imem_rdata};

  mips_fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_ibuf (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.redirect),
    .push_i  (buf_push),
    .data_i  (push_e),
    .pop_i   (buf_pop),
    .data_o  (head),
    .count_o (occ)
  );

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect) pc_d = {bus.redirect_pc[31:2], 2'b00};
    else if (gnt)     pc_d = pc_q + 32'd4;
  end

  always_comb begin
    drop_d = drop_q;
    if (bus.redirect)               drop_d = outst + CW'(gnt) - CW'(rsp);
    else if (rsp && drop_q != '0)   drop_d = drop_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= {RESET_PC[31:2], 2'b00};
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  assign bus.instr_valid = buf_vld;
  assign bus.instr       = head.word;
  assign bus.instr_pc    = head.pc;
  assign bus.opcode      = op_of(head.word);
  assign bus.fcode       = fn_of(head.word);

`ifdef MIPS_FETCH_PERF_EN
  logic [31:0] fet_q, fet_d, fls_q, fls_d;

  always_comb begin
    fet_d = fet_q + 32'(buf_push);
    fls_d = fls_q + 32'(drop_rsp) + (bus.redirect ? 32'(occ) : 32'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fet_q <= '0;
      fls_q <= '0;
    end else begin
      fet_q <= fet_d;
      fls_q <= fls_d;
    end
  end

  assign perf_fetched = fet_q;
  assign perf_flushed = fls_q;
`endif

endmodule

// File: tb/tb_mips_fetch.sv
// Randomized bench for mips_fetch against a queue-based model of the fetch rules.
// Honours MIPS_FETCH_PERF_EN for the perf counter checks.
module tb_mips_fetch;
  import mips_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_fetch_if bif ();

`ifdef MIPS_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  mips_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
`ifdef MIPS_FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  int total = 0;
  int bad   = 0;

  // model state
  logic [31:0] m_pc;
  logic [31:0] m_tag[$];
  logic [31:0] m_buf[$];
  int          m_drop;
  logic [31:0] m_fet, m_fls;
  // memory side: addresses granted by the DUT, answered in order
  logic [31:0] memq[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_pc = {RPC[31:2], 2'b00};
    m_tag.delete();
    m_buf.delete();
    memq.delete();
    m_drop = 0;
    m_fet  = '0;
    m_fls  = '0;
  endtask

  task automatic drive_idle();
    bif.imem_gnt    = 1'b0;
    bif.imem_rvalid = 1'b0;
    bif.imem_rdata  = '0;
    bif.redirect    = 1'b0;
    bif.redirect_pc = '0;
    bif.instr_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    #1;
    chk("rst_req",     {31'd0, bif.imem_req},    32'd0);
    chk("rst_valid",   {31'd0, bif.instr_valid}, 32'd0);
    chk("rst_addr",    bif.imem_addr, RPC);
    chk("rst_instr",   bif.instr,     32'd0);
    chk("rst_instrpc", bif.instr_pc,  32'd0);
`ifdef MIPS_FETCH_PERF_EN
    chk("rst_perf_fet", perf_fetched, 32'd0);
    chk("rst_perf_fls", perf_flushed, 32'd0);
`endif
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: check at negedge, drive random inputs, advance model at posedge.
  task automatic step(input int pg, input int prv, input int prdy, input int prd,
                      input bit frd, input logic [31:0] frp);
    logic        mreq, g, rv, rdy, rd, g_acc, push, dut_req;
    logic [31:0] rp, t, dut_addr;
    @(negedge clk);
    mreq = (m_tag.size() + m_buf.size()) < DEPTH;
    chk("imem_req", {31'd0, bif.imem_req}, {31'd0, mreq});
    chk("addr_align", {30'd0, bif.imem_addr[1:0]}, 32'd0);
    if (mreq) chk("imem_addr", bif.imem_addr, m_pc);
    chk("instr_valid", {31'd0, bif.instr_valid}, {31'd0, m_buf.size() > 0});
    if (m_buf.size() > 0) begin
      chk("instr_pc", bif.instr_pc, m_buf[0]);
      chk("instr",    bif.instr,    mem_word(m_buf[0]));
      t = mem_word(m_buf[0]);
      chk("opcode", {26'd0, bif.opcode}, {26'd0, t[31:26]});
      chk("fcode",  {26'd0, bif.fcode},  {26'd0, t[5:0]});
    end
`ifdef MIPS_FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fet);
    chk("perf_flushed", perf_flushed, m_fls);
`endif
    dut_req  = bif.imem_req;
    dut_addr = bif.imem_addr;
    g   = $urandom_range(99) < pg;
    rv  = (memq.size() > 0) && ($urandom_range(99) < prv);
    rdy = $urandom_range(99) < prdy;
    rd  = frd || ($urandom_range(99) < prd);
    rp  = frd ? frp : $urandom;
    bif.imem_gnt    = g;
    bif.imem_rvalid = rv;
    bif.imem_rdata  = rv ? mem_word(memq[0]) : $urandom;
    bif.instr_ready = rdy;
    bif.redirect    = rd;
    bif.redirect_pc = rp;
    @(posedge clk);
    if (rv) void'(memq.pop_front());
    if (dut_req && g) memq.push_back(dut_addr);

    g_acc = g && mreq;
    push  = 1'b0;
    t     = '0;
    if (rv) begin
      t = m_tag.pop_front();
      if (m_drop > 0) begin m_drop--; m_fls++; end
      else if (rd)    m_fls++;
      else            push = 1'b1;
    end
    if (g_acc) m_tag.push_back(m_pc);
    if (rd) begin
      m_fls  += m_buf.size();
      m_buf.delete();
      m_drop = m_tag.size();
      m_pc   = {rp[31:2], 2'b00};
    end else begin
      if (m_buf.size() > 0 && rdy) void'(m_buf.pop_front());
      if (push) begin m_buf.push_back(t); m_fet++; end
      if (g_acc) m_pc += 32'd4;
    end
  endtask

  task automatic run(input int n, input int pg, input int prv, input int prdy, input int prd);
    for (int i = 0; i < n; i++) step(pg, prv, prdy, prd, 1'b0, '0);
  endtask

  initial begin
    drive_idle();
    model_clear();
    do_reset();
    // streaming: grant always, 1-cycle latency, consumer always ready
    run(20, 100, 100, 100, 0);
    // consumer stall fills the buffer, then drains
    run(12, 100, 100, 0, 0);
    run(6, 100, 100, 100, 0);
    // grant withheld: address must hold
    run(4, 0, 100, 100, 0);
    run(6, 100, 100, 100, 0);
    // two reads in flight, then redirect to an unaligned target
    run(3, 100, 0, 100, 0);
    step(100, 0, 100, 0, 1'b1, 32'h0000_1003);
    run(12, 100, 100, 100, 0);
    // redirect coinciding with response and pop
    run(3, 100, 100, 0, 0);
    step(100, 100, 100, 0, 1'b1, 32'h0000_2000);
    run(10, 100, 60, 100, 0);
    // randomized traffic
    for (int b = 0; b < 20; b++)
      run(100, $urandom_range(20, 100), $urandom_range(20, 100),
          $urandom_range(10, 100), $urandom_range(0, 8));
    // reset with a full buffer, then restart from RESET_PC
    run(8, 100, 100, 0, 0);
    do_reset();
    run(20, 100, 100, 100, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
